// File: rtl/dm_arb_pkg.sv
// Shared definitions for the data-memory arbiter: FSM state encoding,
// the full byte-enable constant and the default memory depth.
package dm_arb_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      MERGE  = 2'd2,
      RESP   = 2'd3
   } state_t;

   localparam logic [3:0] BE_FULL       = 4'b1111;
   localparam int         DEPTH_DEFAULT = 3072;

   // A store needs a read-modify-write only when some, but not all, lanes are enabled.
   function automatic logic be_partial(input logic [3:0] be);
      return (be != BE_FULL) && (be != 4'b0000);
   endfunction

endpackage

// File: rtl/dm_be_merge.sv
// Byte-lane merge: lane i of the result comes from new_word when be[i] is set,
// otherwise from old_word. Purely combinational.
module dm_be_merge (
   input  logic [31:0] old_word,
   input  logic [31:0] new_word,
   input  logic [3:0]  be,
   output logic [31:0] merged
);

   for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      assign merged[gi*8 +: 8] = be[gi] ? new_word[gi*8 +: 8] : old_word[gi*8 +: 8];
   end

endmodule

// File: rtl/dm_arbiter.sv
// Two-port arbiter in front of a single-port data memory (combinational read,
// synchronous write). Port 0 is the CPU, port 1 is DMA/debug. One access is in
// flight at a time: IDLE (grant) -> ACCESS -> [MERGE] -> RESP -> IDLE.
// Optional feature: define DM_ARB_RR_EN for round-robin arbitration of
// contended requests; otherwise port 0 has fixed priority.
module dm_arbiter
   import dm_arb_pkg::*;
#(
   parameter int DEPTH = DEPTH_DEFAULT
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        p0_req,
   input  logic        p0_we,
   input  logic [31:0] p0_addr,
   input  logic [3:0]  p0_be,
   input  logic [31:0] p0_wdata,
   output logic        p0_gnt,
   output logic        p0_rvalid,
   output logic [31:0] p0_rdata,
   output logic        p0_err,
   input  logic        p1_req,
   input  logic        p1_we,
   input  logic [31:0] p1_addr,
   input  logic [3:0]  p1_be,
   input  logic [31:0] p1_wdata,
   output logic        p1_gnt,
   output logic        p1_rvalid,
   output logic [31:0] p1_rdata,
   output logic        p1_err,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wd,
   output logic        mem_we,
   input  logic [31:0] mem_rd
);

   localparam logic [30:0] DEPTH_W = 31'(DEPTH);

   state_t      state_reg, state_next;
   logic        port_reg;
   logic        we_reg;
   logic [29:0] word_reg;
   logic [3:0]  be_reg;
   logic [31:0] wdata_reg;
   logic        oor_reg;
   logic [31:0] old_reg;
   logic [31:0] rdata_reg [2];

   logic        sel_valid;
   logic        sel_port;
   logic        cap_we;
   logic [29:0] cap_word;
   logic [3:0]  cap_be;
   logic [31:0] cap_wdata;
   logic [31:0] merged;
   logic        enter_resp;
   logic [31:0] resp_data;
   logic        unused_addr_bits;

   // Byte-address bits [1:0] are word-aligned away.
   assign unused_addr_bits = ^{p0_addr[1:0], p1_addr[1:0]};

`ifdef DM_ARB_RR_EN
   logic last_reg;

   // Pick the requester: on contention, the port not granted last wins.
   always_comb begin
      sel_valid = p0_req | p1_req;
      if (p0_req && p1_req) begin
         sel_port = ~last_reg;
      end else begin
         sel_port = p1_req;
      end
   end

   // Remember the last granted port; reset to 1 so port 0 wins first.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         last_reg <= 1'b1;
      end else if (state_reg == IDLE && sel_valid) begin
         last_reg <= sel_port;
      end
   end
`else
   // Pick the requester: port 0 always has priority.
   always_comb begin
      sel_valid = p0_req | p1_req;
      sel_port  = ~p0_req;
   end
`endif

   // Mux the selected requester's command for capture.
   always_comb begin
      cap_we    = sel_port ? p1_we          : p0_we;
      cap_word  = sel_port ? p1_addr[31:2]  : p0_addr[31:2];
      cap_be    = sel_port ? p1_be          : p0_be;
      cap_wdata = sel_port ? p1_wdata       : p0_wdata;
   end

   dm_be_merge u_merge (
      .old_word (old_reg),
      .new_word (wdata_reg),
      .be       (be_reg),
      .merged   (merged)
   );

   // Next-state logic.
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:    if (sel_valid) state_next = ACCESS;
         ACCESS:  state_next = (we_reg && !oor_reg && be_partial(be_reg)) ? MERGE : RESP;
         MERGE:   state_next = RESP;
         RESP:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Response data is captured on the way into RESP: loads take the memory word,
   // stores and out-of-range accesses report zero.
   always_comb begin
      enter_resp = (state_reg == ACCESS || state_reg == MERGE) && (state_next == RESP);
      resp_data  = (!we_reg && !oor_reg) ? mem_rd : 32'h0;
   end

   // Port and memory outputs, all decoded from the current state.
   always_comb begin
      p0_gnt    = reset && (state_reg == IDLE) && sel_valid && !sel_port;
      p1_gnt    = reset && (state_reg == IDLE) && sel_valid &&  sel_port;
      p0_rvalid = (state_reg == RESP) && !port_reg;
      p1_rvalid = (state_reg == RESP) &&  port_reg;
      p0_err    = p0_rvalid && oor_reg;
      p1_err    = p1_rvalid && oor_reg;
      mem_addr  = (state_reg == IDLE) ? 32'h0 : {word_reg, 2'b00};
      mem_we    = 1'b0;
      mem_wd    = 32'h0;
      if (state_reg == ACCESS && we_reg && !oor_reg && be_reg == BE_FULL) begin
         mem_we = 1'b1;
         mem_wd = wdata_reg;
      end else if (state_reg == MERGE) begin
         mem_we = 1'b1;
         mem_wd = merged;
      end
   end

   assign p0_rdata = rdata_reg[0];
   assign p1_rdata = rdata_reg[1];

   // State register and command/data capture; reset aborts any access in flight.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_reg    <= IDLE;
         port_reg     <= 1'b0;
         we_reg       <= 1'b0;
         word_reg     <= '0;
         be_reg       <= '0;
         wdata_reg    <= '0;
         oor_reg      <= 1'b0;
         old_reg      <= '0;
         rdata_reg[0] <= '0;
         rdata_reg[1] <= '0;
      end else begin
         state_reg <= state_next;
         if (state_reg == IDLE && sel_valid) begin
            port_reg  <= sel_port;
            we_reg    <= cap_we;
            word_reg  <= cap_word;
            be_reg    <= cap_be;
            wdata_reg <= cap_wdata;
            oor_reg   <= ({1'b0, cap_word} >= DEPTH_W);
         end
         if (state_reg == ACCESS) begin
            old_reg <= mem_rd;
         end
         if (enter_resp) begin
            rdata_reg[port_reg] <= resp_data;
         end
      end
   end

endmodule
